// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared adder-family constants, FSM encodings and helpers
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } add_state_t;

  // One extra bit so the bit counter cannot wrap at WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller, LSB first, one bit per clock
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  add_state_t       state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  fulladder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        last_bit = (cnt == LAST);
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B at load and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == ST_RUN) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        c_out    <= fa_co;
        overflow <= carry ^ fa_co;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b, sum;
  logic       busy, done, c_out, overflow;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Latency counts edges from the accepting edge inclusive: done after WIDTH+1 edges.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                        input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int n;
    a = ia; b = ib; sub = isub; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, ec);
    check({tag, "_ovf"}, overflow, eo);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    step();
    step();
    check({tag, "_sum_hold"}, sum, es);
  endtask

  logic [7:0] ta [3];
  logic [7:0] tb_ [3];
  logic       ts [3];
  logic [7:0] tsum [3];
  logic       tc [3];
  logic       to [3];
  int         tdone [3];

  initial begin
    int n, pulses;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", c_out, 0);
    check("rst_ovf", overflow, 0);

    // rst wins over start on the same edge
    start = 1'b1; a = 8'h11; b = 8'h22;
    step();
    check("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    step();
    check("idle_no_start", busy, 0);

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_00_00");

    // start re-asserted mid-RUN with different operands is ignored
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    step(); n++;
    step(); n++;
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    step(); n++;
    start = 1'b0;
    check("inject_busy", busy, 1);
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("inject_latency", n, 9);
    check("inject_sum", sum, 8'h10);
    check("inject_cout", c_out, 0);
    check("inject_ovf", overflow, 0);
    pulses = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done) pulses++;
    end
    check("inject_pulses", pulses, 1);

    // reset mid-operation aborts without a done pulse
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 8'h00);
    check("abort_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_abort");

    // back-to-back with start held high
    ta[0] = 8'h01; tb_[0] = 8'h02; ts[0] = 1'b0; tsum[0] = 8'h03; tc[0] = 1'b0; to[0] = 1'b0;
    ta[1] = 8'h7F; tb_[1] = 8'h01; ts[1] = 1'b0; tsum[1] = 8'h80; tc[1] = 1'b0; to[1] = 1'b1;
    ta[2] = 8'h05; tb_[2] = 8'h07; ts[2] = 1'b1; tsum[2] = 8'hFE; tc[2] = 1'b0; to[2] = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = ta[k]; b = tb_[k]; sub = ts[k];
      step();
      n = 1;
      while (!done && n < 20) begin
        step();
        n++;
      end
      tdone[k] = cyc;
      check($sformatf("b2b%0d_latency", k), n, 9);
      check($sformatf("b2b%0d_sum", k), sum, tsum[k]);
      check($sformatf("b2b%0d_cout", k), c_out, tc[k]);
      check($sformatf("b2b%0d_ovf", k), overflow, to[k]);
      step();
      check($sformatf("b2b%0d_idle", k), busy, 0);
    end
    start = 1'b0;
    check("b2b_spacing01", tdone[1] - tdone[0], 10);
    check("b2b_spacing12", tdone[2] - tdone[1], 10);
    step();
    check("b2b_stopped", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
